// File: rtl/qs_link_pkg.sv
// ============================================================================
// qs_link_pkg : shared constants, field layout and FSM states of the
//               host <-> quad-stepper 64-bit SPI link.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package qs_link_pkg;

   localparam int FRAME_BITS  = 64;

   // Command frame fields
   localparam int PERIOD_LSB  = 0;
   localparam int PERIOD_W    = 32;
   localparam int DIR_BIT     = 32;

   // Status frame fields
   localparam int STEPPER_LSB = 0;
   localparam int ENCODER_LSB = 32;
   localparam int POS_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LEAD     = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_TRAIL    = 3'd4,
      ST_GAP      = 3'd5
   } qs_state_e;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// sync2 : two-flop synchronizer for a single asynchronous bit, resets to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/qs_spi_master.sv
// ============================================================================
// qs_spi_master : mode-0 SPI master, one 64-bit full-duplex frame per start.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module qs_spi_master #(
   parameter int FRAME_BITS = 64,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [FRAME_BITS-1:0] i_tx_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [FRAME_BITS-1:0] o_rx_data,
   output logic                  o_sck,
   output logic                  o_mosi,
   input  logic                  i_miso,
   output logic                  o_cs
);
   import qs_link_pkg::*;

   localparam logic [7:0] C_HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [6:0] C_BIT_LAST  = 7'(FRAME_BITS - 1);

   qs_state_e             r_state;
   qs_state_e             w_state_nxt;
   logic [7:0]            r_hcnt;
   logic [6:0]            r_bit;
   logic [FRAME_BITS-1:0] r_tx;
   logic [FRAME_BITS-1:0] r_rx;
   logic [FRAME_BITS-1:0] r_rx_data;
   logic                  r_sck;
   logic                  r_cs;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_miso_s;
   logic                  w_last;

   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (i_miso),
      .o_q   (w_miso_s)
   );

   assign w_last = (r_hcnt == C_HALF_LAST);

   // The final SCK-low half-period is spent in TRAIL, so the last high
   // half-period hands over to TRAIL directly instead of to SHIFT_LO.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (i_start) w_state_nxt = ST_LEAD;
         ST_LEAD:     if (w_last)  w_state_nxt = ST_SHIFT_HI;
         ST_SHIFT_HI: if (w_last)  w_state_nxt = (r_bit == C_BIT_LAST) ? ST_TRAIL : ST_SHIFT_LO;
         ST_SHIFT_LO: if (w_last)  w_state_nxt = ST_SHIFT_HI;
         ST_TRAIL:    if (w_last)  w_state_nxt = ST_GAP;
         ST_GAP:      if (w_last)  w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Pin outputs are registered from the next state to keep them glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hcnt    <= '0;
         r_bit     <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_sck     <= 1'b0;
         r_cs      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_hcnt <= (w_state_nxt != r_state) ? 8'd0 : r_hcnt + 8'd1;
         r_sck  <= (w_state_nxt == ST_SHIFT_HI);
         r_cs   <= !(w_state_nxt inside {ST_LEAD, ST_SHIFT_HI, ST_SHIFT_LO, ST_TRAIL});
         r_busy <= (w_state_nxt != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_tx  <= i_tx_data;
                  r_bit <= '0;
               end
            end
            ST_SHIFT_HI: begin
               if (w_last) begin
                  r_rx  <= {r_rx[FRAME_BITS-2:0], w_miso_s};
                  r_tx  <= {r_tx[FRAME_BITS-2:0], 1'b0};
                  r_bit <= r_bit + 7'd1;
               end
            end
            ST_TRAIL: begin
               if (w_last) begin
                  r_rx_data <= r_rx;
                  r_done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rx_data = r_rx_data;
   assign o_sck     = r_sck;
   assign o_mosi    = r_tx[FRAME_BITS-1];
   assign o_cs      = r_cs;

endmodule

`default_nettype wire
